// File: rtl/cvt_sequencer.sv
// cvt_sequencer
//   Job sequencer for the integer-to-float converter. Accepts a 16-bit
//   operand, writes it into the converter's data memory, pulses cvt_start,
//   waits for cvt_done (with a watchdog), reads the half-precision result
//   back and returns it over a valid/ready response port.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   req_valid/req_ready      operand request handshake, req_data = operand
//   rsp_valid/rsp_ready      response handshake, rsp_data = result,
//                            rsp_err = watchdog timeout (rsp_data = 0)
//   mem_addr/we/wdata/rdata  data memory port (rdata one cycle after addr)
//   cvt_start/cvt_done       converter start pulse / level-sensitive done
//   busy                     high whenever a job is in progress
//   job_count/err_count      successful (wrapping) / error (saturating) jobs
module cvt_sequencer #(
  parameter int         TIMEOUT_CYCLES = 4095,
  parameter logic [7:0] OP_ADDR        = 8'd0,
  parameter logic [7:0] RES_ADDR       = 8'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [15:0] req_data,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        cvt_start,
  input  logic        cvt_done,
  output logic        busy,
  output logic [7:0]  job_count,
  output logic [7:0]  err_count
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_LO, S_WR_HI, S_START, S_WAIT_LOW,
    S_WAIT_DONE, S_RD_LO, S_RD_HI, S_RD_CAP, S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [15:0]   r_op;
  logic [7:0]    r_res_lo;
  logic [CW-1:0] r_tmo_cnt;

  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [15:0]   r_rsp_data;
  logic          r_rsp_err;
  logic [7:0]    r_mem_addr;
  logic          r_mem_we;
  logic [7:0]    r_mem_wdata;
  logic          r_cvt_start;
  logic          r_busy;
  logic [7:0]    r_job_count;
  logic [7:0]    r_err_count;

  logic          w_tmo_last;
  logic          w_tmo_fire;
  logic [15:0]   w_op;
  logic          w_mem_we_next;
  logic [7:0]    w_mem_addr_next;
  logic [7:0]    w_mem_wdata_next;

  // Watchdog expires only when the wait state's exit condition is absent;
  // an exit seen on the last allowed cycle still wins.
  assign w_tmo_last = (r_tmo_cnt == TMO_LAST);
  assign w_tmo_fire = w_tmo_last &&
                      (((r_state == S_WAIT_LOW)  &&  cvt_done) ||
                       ((r_state == S_WAIT_DONE) && !cvt_done));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (req_valid) w_state_next = S_WR_LO;
      S_WR_LO:     w_state_next = S_WR_HI;
      S_WR_HI:     w_state_next = S_START;
      S_START:     w_state_next = S_WAIT_LOW;
      // done is still high from the previous job until the converter
      // acknowledges the new start, so wait for it to drop first
      S_WAIT_LOW:  if (!cvt_done)      w_state_next = S_WAIT_DONE;
                   else if (w_tmo_fire) w_state_next = S_RESP;
      S_WAIT_DONE: if (cvt_done)        w_state_next = S_RD_LO;
                   else if (w_tmo_fire) w_state_next = S_RESP;
      S_RD_LO:     w_state_next = S_RD_HI;
      S_RD_HI:     w_state_next = S_RD_CAP;
      S_RD_CAP:    w_state_next = S_RESP;
      S_RESP:      if (rsp_ready) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Output decode. Outputs are registered, so they are decoded from the
  // state being entered. On the accept edge the operand is not yet in r_op,
  // hence the bypass from req_data.
  always_comb begin
    w_op             = (r_state == S_IDLE) ? req_data : r_op;
    w_mem_we_next    = 1'b0;
    w_mem_addr_next  = 8'd0;
    w_mem_wdata_next = 8'd0;
    case (w_state_next)
      S_WR_LO: begin
        w_mem_we_next    = 1'b1;
        w_mem_addr_next  = OP_ADDR;
        w_mem_wdata_next = w_op[7:0];
      end
      S_WR_HI: begin
        w_mem_we_next    = 1'b1;
        w_mem_addr_next  = OP_ADDR + 8'd1;
        w_mem_wdata_next = w_op[15:8];
      end
      S_RD_LO: w_mem_addr_next = RES_ADDR;
      S_RD_HI: w_mem_addr_next = RES_ADDR + 8'd1;
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'd0;
      r_rsp_err   <= 1'b0;
      r_mem_addr  <= 8'd0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 8'd0;
      r_cvt_start <= 1'b0;
      r_busy      <= 1'b0;
      r_job_count <= 8'd0;
      r_err_count <= 8'd0;
      r_op        <= 16'd0;
      r_res_lo    <= 8'd0;
      r_tmo_cnt   <= '0;
    end else begin
      r_req_ready <= (w_state_next == S_IDLE);
      r_busy      <= (w_state_next != S_IDLE);
      r_rsp_valid <= (w_state_next == S_RESP);
      r_cvt_start <= (w_state_next == S_START);
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;

      if ((r_state == S_IDLE) && req_valid) r_op <= req_data;

      case (r_state)
        S_START:                 r_tmo_cnt <= '0;
        S_WAIT_LOW, S_WAIT_DONE: r_tmo_cnt <= r_tmo_cnt + CW'(1);
        default: ;
      endcase

      // Read data lags the address by one cycle: the low byte arrives
      // while in RD_HI, the high byte while in RD_CAP.
      if (r_state == S_RD_HI) r_res_lo <= mem_rdata;
      if (r_state == S_RD_CAP) begin
        r_rsp_data <= {mem_rdata, r_res_lo};
        r_rsp_err  <= 1'b0;
      end
      if (w_tmo_fire) begin
        r_rsp_data <= 16'd0;
        r_rsp_err  <= 1'b1;
      end

      if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_data <= 16'd0;
        r_rsp_err  <= 1'b0;
        if (r_rsp_err) begin
          if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end else begin
          r_job_count <= r_job_count + 8'd1;
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign cvt_start = r_cvt_start;
  assign busy      = r_busy;
  assign job_count = r_job_count;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_cvt_sequencer.sv
// Testbench for cvt_sequencer: behavioural memory + converter, a response
// scoreboard (queue + monitor) and a per-job timeline check derived from
// the job timing rules (offsets counted from the accept edge).
module tb_cvt_sequencer;

  localparam int TMO = 16;
  localparam int OPA = 0;
  localparam int RSA = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_data = 16'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready = 1'b0;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'd0;
  logic        cvt_start;
  logic        cvt_done = 1'b1;
  logic        busy;
  logic [7:0]  job_count;
  logic [7:0]  err_count;

  cvt_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .OP_ADDR(8'd0),
    .RES_ADDR(8'd2)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .cvt_start(cvt_start), .cvt_done(cvt_done),
    .busy(busy), .job_count(job_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_rsp = 0;
  logic [16:0] exp_q[$];       // {rsp_data, rsp_err}
  logic [7:0]  exp_job = 8'd0;
  logic [7:0]  exp_err = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Truncating int16 -> fp16 conversion, as the real converter does.
  function automatic logic [15:0] fp16_of(input logic [15:0] x);
    logic [16:0] mag;
    logic [31:0] m;
    int p;
    if (x == 16'd0) return 16'd0;
    mag = x[15] ? (17'h10000 - {1'b0, x}) : {1'b0, x};
    p = 0;
    for (int i = 0; i < 17; i++) if (mag[i]) p = i;
    if (p >= 10) m = 32'(mag) >> (p - 10);
    else         m = 32'(mag) << (10 - p);
    return {x[15], 5'(15 + p), m[9:0]};
  endfunction

  // Behavioural data memory and converter. After start, done drops after
  // conv_drop edges and rises conv_lat edges later (never if hang).
  logic [7:0]  mem [0:255];
  logic [15:0] conv_res;
  int  conv_drop = 0;
  int  conv_lat = 0;
  bit  hang = 1'b0;
  int  el = 0;
  bit  cbusy = 1'b0;

  always_comb conv_res = fp16_of({mem[OPA + 1], mem[OPA]});

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (cvt_start) begin
      el    <= 0;
      cbusy <= 1'b1;
      if (conv_drop == 0) cvt_done <= 1'b0;
    end else if (cbusy) begin
      el <= el + 1;
      if (el + 1 == conv_drop) cvt_done <= 1'b0;
      if (el == conv_drop + conv_lat) begin
        cbusy <= 1'b0;
        if (!hang) begin
          cvt_done     <= 1'b1;
          mem[RSA]     <= conv_res[7:0];
          mem[RSA + 1] <= conv_res[15:8];
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every handoff.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_data), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e[16:1]));
          chk("rsp_err", 32'(rsp_err), 32'(e[0]));
          $display("RSP %0d data=%h err=%0d expected=%h/%0d", n_rsp, rsp_data, rsp_err, e[16:1], e[0]);
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_err",   32'(rsp_err), 0);
    chk("rst_rsp_data",  32'(rsp_data), 0);
    chk("rst_mem_we",    32'(mem_we), 0);
    chk("rst_mem_addr",  32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_cvt_start", 32'(cvt_start), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_job_count", 32'(job_count), 0);
    chk("rst_err_count", 32'(err_count), 0);
  endtask

  // Waits (bounded) at negedges until req_ready; returns 1 if seen.
  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // One complete job, entered and left at a negedge. Checks every cycle
  // against the job timeline; the response value goes to the scoreboard.
  task automatic run_job(input logic [15:0] op, input int drop, input int lat,
                         input int hold, input bit hang_i, input bit keep);
    bit to, ok;
    int r_off, k_end;
    logic [15:0] ed;
    logic [7:0] ea;
    to    = hang_i || (drop + lat > TMO - 2);
    r_off = to ? (3 + TMO + 1) : (9 + drop + lat);
    k_end = r_off + hold + 1;
    ed    = to ? 16'd0 : fp16_of(op);
    conv_drop = drop;
    conv_lat  = lat;
    hang      = hang_i;
    req_data  = op;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    wait_ready(ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back({ed, to});
    for (int k = 1; k <= k_end; k++) begin
      @(negedge clk);
      if (k == 1) req_data = 16'($urandom);  // operand must already be latched
      if (k == k_end) begin
        if (to) exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
        else    exp_job = exp_job + 8'd1;
      end
      ea = 8'd0;
      if (k == 1) ea = 8'(OPA);
      if (k == 2) ea = 8'(OPA + 1);
      if (!to && k == r_off - 3) ea = 8'(RSA);
      if (!to && k == r_off - 2) ea = 8'(RSA + 1);
      chk("mem_we",    32'(mem_we), 32'(k <= 2));
      chk("mem_addr",  32'(mem_addr), 32'(ea));
      chk("mem_wdata", 32'(mem_wdata), (k == 1) ? 32'(op[7:0]) : (k == 2) ? 32'(op[15:8]) : 0);
      chk("cvt_start", 32'(cvt_start), 32'(k == 3));
      chk("rsp_valid", 32'(rsp_valid), 32'(k >= r_off && k < k_end));
      chk("req_ready", 32'(req_ready), 32'(k == k_end));
      chk("busy",      32'(busy), 32'(k < k_end));
      chk("job_count", 32'(job_count), 32'(exp_job));
      chk("err_count", 32'(err_count), 32'(exp_err));
      if (k >= r_off && k < k_end) begin
        chk("rsp_data_hold", 32'(rsp_data), 32'(ed));
        chk("rsp_err_hold",  32'(rsp_err), 32'(to));
      end
      rsp_ready = (k == k_end - 1);
    end
    rsp_ready = 1'b0;
    req_data  = op;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic reset_mid_job(input logic [15:0] op);
    bit ok;
    conv_drop = 0;
    conv_lat  = 8;
    hang      = 1'b0;
    req_data  = op;
    req_valid = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    repeat (6) @(negedge clk);          // now in WAIT_DONE
    chk("busy_before_reset", 32'(busy), 1);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    exp_job = 8'd0;
    exp_err = 8'd0;
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    $display("RESET mid-job op=%h", op);
  endtask

  initial begin
    bit kp, prev_keep;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    chk("first_req_ready", 32'(req_ready), 1);
    chk("first_busy", 32'(busy), 0);

    // Minimum-latency job, then back-to-back with req_valid held high
    run_job(16'h0001, 0, 0, 0, 1'b0, 1'b0);
    run_job(16'h7FFF, 0, 1, 0, 1'b0, 1'b1);
    run_job(16'h0000, 1, 0, 0, 1'b0, 1'b1);
    run_job(16'h8000, 0, 2, 0, 1'b0, 1'b0);
    // Memory port pattern
    run_job(16'hA5C3, 0, 3, 0, 1'b0, 1'b0);
    // Converter that never finishes, then a good job
    run_job(16'h1234, 0, 0, 0, 1'b1, 1'b0);
    run_job(16'h0100, 0, 1, 0, 1'b0, 1'b0);
    // Done on the last watchdog cycle wins; one cycle later times out
    run_job(16'hFFFF, 0, TMO - 2, 0, 1'b0, 1'b0);
    run_job(16'h0ABC, 0, TMO - 1, 0, 1'b0, 1'b0);
    // Stale-high done from the late converter is absorbed
    run_job(16'hF00D, 3, 2, 0, 1'b0, 1'b0);
    // Response backpressure
    run_job(16'h4321, 0, 2, 10, 1'b0, 1'b0);
    // Reset during WAIT_DONE, then a normal job
    reset_mid_job(16'h5555);
    run_job(16'h0001, 0, 0, 0, 1'b0, 1'b0);

    // Randomized jobs
    prev_keep = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!prev_keep) repeat ($urandom_range(0, 3)) @(negedge clk);
      kp = (i != 29) && ($urandom_range(0, 1) == 1);
      run_job(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 5),
              $urandom_range(0, 3), ($urandom_range(0, 9) == 0), kp);
      prev_keep = kp;
    end

    // Error counter saturation
    for (int i = 0; i < 256; i++) run_job(16'($urandom), 0, 0, 0, 1'b1, 1'b0);
    run_job(16'h0003, 0, 0, 0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/cvt_sequencer.md
# cvt_sequencer

Job sequencer for the integer-to-float converter and its data memory. It accepts 16-bit integer operands over a valid/ready request port and writes each operand into data memory bytes 0–1. It then pulses the converter's start, waits for done, reads the half-precision result from bytes 2–3, and returns it over a valid/ready response port. A timeout watchdog reports a converter that never finishes. The block sits between the program-level test harness and the converter, and it is the converter's only source of start.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 4095: maximum number of cycles spent waiting on the converter before an error response; the minimum legal value is 2.
- OP_ADDR, default 8'd0: address of the operand low byte. The high byte is at OP_ADDR+1.
- RES_ADDR, default 8'd2: address of the result low byte. The high byte is at RES_ADDR+1.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- req_valid, in, 1: an operand is offered.
- req_data, in, 16: two's-complement integer operand.
- req_ready, out, 1: the sequencer can accept an operand; high only in IDLE.
- rsp_valid, out, 1: a result is available.
- rsp_data, out, 16: result as {sign, exp[4:0], mant[9:0]}; forced to 0 on error.
- rsp_err, out, 1: the response is a timeout error.
- rsp_ready, in, 1: the consumer accepts the response.
- mem_addr, out, 8: data memory address.
- mem_we, out, 1: data memory write enable.
- mem_wdata, out, 8: data memory write data.
- mem_rdata, in, 8: data memory read data, valid one cycle after mem_addr is presented.
- cvt_start, out, 1: one-cycle start pulse to the converter.
- cvt_done, in, 1: converter done/acknowledge, level-sensitive.
- busy, out, 1: high in any state other than IDLE.
- job_count, out, 8: number of successful responses handed off; wraps at 255→0.
- err_count, out, 8: number of error responses handed off; saturates at 255.

## Operation
- All state and outputs are registered.
- FSM states: IDLE → WR_LO → WR_HI → START → WAIT_LOW → WAIT_DONE → RD_LO → RD_HI → RD_CAP → RESP → IDLE.
- **IDLE:** req_ready=1. When req_valid is high, the operand is latched into an internal register and the FSM goes to WR_LO.
- **WR_LO:** mem_we=1, mem_addr=OP_ADDR, mem_wdata=op[7:0].
- **WR_HI:** mem_we=1, mem_addr=OP_ADDR+1, mem_wdata=op[15:8].
- **START:** cvt_start=1 for exactly this cycle. The timeout counter is cleared to 0.
- **WAIT_LOW:** waits for cvt_done=0, because done is stale-high from the previous job. On cvt_done=0 the FSM goes to WAIT_DONE.
- **WAIT_DONE:** on cvt_done=1 the FSM goes to RD_LO.
- **Timeout:** in WAIT_LOW and WAIT_DONE the counter increments each cycle. When the counter equals TIMEOUT_CYCLES-1 and the exit condition is not met, the FSM goes to RESP with rsp_err=1 and rsp_data=0. If the exit condition and the timeout occur in the same cycle, the exit condition wins.
- **RD_LO:** mem_addr=RES_ADDR.
- **RD_HI:** mem_addr=RES_ADDR+1; mem_rdata is captured as result[7:0].
- **RD_CAP:** mem_rdata is captured as result[15:8].
- **RESP:** rsp_valid=1. rsp_data and rsp_err are held stable while rsp_ready=0. On rsp_ready=1 the FSM returns to IDLE, and job_count or err_count increments on that same edge.
- A new request is accepted no earlier than the cycle after the handoff.
- **Idle memory port:** outside the write states mem_we=0 and mem_wdata=0. Outside the access states mem_addr=0.
- **Converter data:** the sequencer never inspects or modifies result bits; the conversion itself, including the 0 and 16'h8000 traps, belongs to the converter.
- **Late done after timeout:** a cvt_done that arrives after a timeout is ignored. The next job's WAIT_LOW absorbs any stale done level.

## Timing
- **Reset values:** req_ready=0 during reset and 1 on the first cycle after it. rsp_valid, rsp_err, rsp_data, mem_we, mem_addr, mem_wdata, cvt_start, busy, job_count and err_count are all 0. The FSM is in IDLE.
- **Reset mid-job:** the FSM returns to IDLE on the next edge, with no response and no counter change. A cvt_start that is in progress ends that cycle.
- **Request side:** the accept edge is A. The write to OP_ADDR occurs in cycle A+1, the write to OP_ADDR+1 in cycle A+2, and cvt_start=1 in cycle A+3.
- **Response side:** the edge that samples cvt_done=1 in WAIT_DONE is E. rsp_valid rises after edge E+3, so there are 3 edges from done to response.
- **Minimum job time:** with a converter whose done drops on the start edge and returns one cycle later, the minimum time from accept to rsp_valid is 9 cycles.
- **Timeout response:** rsp_valid is asserted exactly TIMEOUT_CYCLES+1 cycles after the cycle in which cvt_start is high.

## Test plan
- **Basic conversions.** Use the behavioral converter and memory, and send 16'h0001 → rsp_data=16'h3C00, rsp_err=0, job_count=1. Back-to-back jobs with req_valid held high: 16'h7FFF → 16'h77FF, then 16'h0000 → 16'h0000, then 16'h8000 → 16'hF800. The bench checks that cvt_start pulses once per job and that req_ready is 0 throughout.
- **Memory port check.** For operand 16'hA5C3, the bench checks cycle by cycle that WR_LO writes 8'hC3 at address 0 and WR_HI writes 8'hA5 at address 1. Required: no other mem_we pulses, and the reads hit addresses 2 then 3.
- **Timeout.** Set TIMEOUT_CYCLES=16 and use a converter stub that holds cvt_done=0 forever. Required: rsp_valid exactly 17 cycles after cvt_start, with rsp_err=1, rsp_data=0 and err_count=1. A following good job must still complete correctly.
- **Response backpressure.** Hold rsp_ready=0 for 10 cycles after rsp_valid. Required: rsp_data, rsp_err and rsp_valid stay stable, req_ready=0, and job_count is unchanged until the handoff edge.
- **Reset mid-job.** Assert reset during WAIT_DONE. Required: all outputs return to their reset values, no response is produced, and job_count=0. The next operand, 16'h0001, must return 16'h3C00.
